// File: rtl/rst_seq_xil7series.sv
// rst_seq_xil7series
//   Reset sequencer that follows the PLL clock generator and runs on the
//   generated system clock. It synchronises the PLL lock flag, holds every
//   reset domain for HOLD_CYCLES, then releases the NUM_RST active-low resets
//   one after another, STAGE_GAP cycles apart. Lock loss or a software reset
//   request re-asserts every domain at once. Lock-loss events are recorded in
//   a sticky flag and, optionally, in a saturating counter.
//
//   Optional feature macro: RST_SEQ_LOCK_CNT_EN
//     defined   -> lock_loss_cnt_o counts lock-loss events and saturates at 8'hFF
//     undefined -> no counter logic; lock_loss_cnt_o is tied to 8'h00
//
//   Ports
//     clk_sys          in   system clock (single clock domain)
//     rst_sys_n        in   asynchronous active-low reset
//     pll_locked_i     in   PLL LOCKED, asynchronous, synchronised internally
//     sw_rst_req_i     in   one-cycle software reset request
//     lock_lost_clr_i  in   clears lock_lost_o
//     rst_n_o          out  sequenced active-low resets, bit 0 releases first
//     rst_done_o       out  high while every channel is released
//     lock_lost_o      out  sticky lock-loss flag
//     lock_loss_cnt_o  out  saturating lock-loss event count
module rst_seq_xil7series #(
  parameter int NUM_RST     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  input  logic               pll_locked_i,
  input  logic               sw_rst_req_i,
  input  logic               lock_lost_clr_i,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               rst_done_o,
  output logic               lock_lost_o,
  output logic [7:0]         lock_loss_cnt_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_RST-1:0]     rstN_q;
  logic                   done_q;
  logic                   lockLost_q;
  logic                   lockedS;
  logic                   lockLossEvent;

  // The lock flag comes straight from the PLL with no relation to clk_sys,
  // so it passes through a plain shift-register synchroniser first.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign lockedS = sync_q[SYNC_STAGES-1];

  // A lock-loss event is any cycle where the synchronised lock flag is low
  // while the sequencer has already left WAIT_LOCK; this is exactly the
  // condition that sends the FSM back to WAIT_LOCK.
  assign lockLossEvent = (state_q != WAIT_LOCK) && !lockedS;

  // Sequencing FSM. Released channels are tracked directly in rstN_q: the
  // next channel is released by shifting in another 1, so the channels fill
  // from bit 0 upwards and the top bit tells us every channel is out of
  // reset. Lock loss is checked before the software request so that lock
  // loss wins when both happen in the same cycle.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rstN_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rstN_q <= '0;
          done_q <= 1'b0;
          if (lockedS) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end
        default: begin
          if (!lockedS) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rstN_q  <= '0;
            done_q  <= 1'b0;
          end else if (sw_rst_req_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rstN_q  <= '0;
            done_q  <= 1'b0;
          end else begin
            case (state_q)
              HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
                  rstN_q  <= NUM_RST'(1);
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              RELEASE: begin
                if (rstN_q[NUM_RST-1]) begin
                  state_q <= RUN;
                  done_q  <= 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                  cnt_q  <= '0;
                  rstN_q <= (rstN_q << 1) | NUM_RST'(1);
                end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
              RUN: begin
                done_q <= 1'b1;
              end
              default: begin
                state_q <= WAIT_LOCK;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Sticky lock-loss flag; a new event in the same cycle as a clear keeps
  // the flag set so no event is ever silently dropped.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      lockLost_q <= 1'b0;
    end else if (lockLossEvent) begin
      lockLost_q <= 1'b1;
    end else if (lock_lost_clr_i) begin
      lockLost_q <= 1'b0;
    end
  end

`ifdef RST_SEQ_LOCK_CNT_EN
  logic [7:0] lockCnt_q;

  // Saturating event counter; only the system reset clears it.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      lockCnt_q <= 8'h00;
    end else if (lockLossEvent && (lockCnt_q != 8'hFF)) begin
      lockCnt_q <= lockCnt_q + 8'h01;
    end
  end

  assign lock_loss_cnt_o = lockCnt_q;
`else
  assign lock_loss_cnt_o = 8'h00;
`endif

  assign rst_n_o     = rstN_q;
  assign rst_done_o  = done_q;
  assign lock_lost_o = lockLost_q;

endmodule

// File: tb/tb_rst_seq_xil7series.sv
// tb_rst_seq_xil7series
//   Directed bench for rst_seq_xil7series at its default parameters
//   (NUM_RST=4, HOLD_CYCLES=16, STAGE_GAP=8, SYNC_STAGES=2). Expected values
//   are hand-derived from the release timeline: with E the edge at which the
//   synchronised lock flag goes high, bit k releases at E+17+8k and
//   rst_done_o rises at E+42.
module tb_rst_seq_xil7series;

`ifdef RST_SEQ_LOCK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_sys;
  logic       rst_sys_n;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic       lock_lost_clr_i;
  logic [3:0] rst_n_o;
  logic       rst_done_o;
  logic       lock_lost_o;
  logic [7:0] lock_loss_cnt_o;

  int vectors;
  int miscompares;

  rst_seq_xil7series #(
    .NUM_RST    (4),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .STAGE_GAP  (8)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_sys_n      (rst_sys_n),
    .pll_locked_i   (pll_locked_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .lock_lost_clr_i(lock_lost_clr_i),
    .rst_n_o        (rst_n_o),
    .rst_done_o     (rst_done_o),
    .lock_lost_o    (lock_lost_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  // 10 ns system clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Drive all synchronous inputs together.
  task automatic applyStimulus(input logic pll, input logic sw, input logic clr);
    pll_locked_i    = pll;
    sw_rst_req_i    = sw;
    lock_lost_clr_i = clr;
  endtask

  // Advance n rising edges and land 1 ns after the last one, away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // One comparison: counts it, and on a mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence: reset, full release timeline, lock loss, clear,
  // software reset in RELEASE, set-vs-clear race, lock loss racing a
  // software request, counter saturation, and async reset mid-RUN.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_sys_n   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    #3;
    checkOutput("reset_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("reset_done", 32'(rst_done_o), 32'h0);
    checkOutput("reset_lock_lost", 32'(lock_lost_o), 32'h0);
    checkOutput("reset_cnt", 32'(lock_loss_cnt_o), 32'h0);

    @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b1;
    tick(3);
    checkOutput("wait_lock_rst_n", 32'(rst_n_o), 32'h0);

    $display("[TB] release timeline");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    tick(16);
    checkOutput("E16_rst_n", 32'(rst_n_o), 32'h0);
    tick(1);
    checkOutput("E17_rst_n", 32'(rst_n_o), 32'h1);
    tick(7);
    checkOutput("E24_rst_n", 32'(rst_n_o), 32'h1);
    tick(1);
    checkOutput("E25_rst_n", 32'(rst_n_o), 32'h3);
    tick(8);
    checkOutput("E33_rst_n", 32'(rst_n_o), 32'h7);
    tick(8);
    checkOutput("E41_rst_n", 32'(rst_n_o), 32'hF);
    checkOutput("E41_done", 32'(rst_done_o), 32'h0);
    tick(1);
    checkOutput("E42_done", 32'(rst_done_o), 32'h1);
    checkOutput("E42_rst_n", 32'(rst_n_o), 32'hF);

    $display("[TB] lock loss in RUN");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("loss_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("loss_done", 32'(rst_done_o), 32'h0);
    checkOutput("loss_flag", 32'(lock_lost_o), 32'h1);
    checkOutput("loss_cnt1", 32'(lock_loss_cnt_o), CNT_EN ? 32'd1 : 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_alone", 32'(lock_lost_o), 32'h0);
    checkOutput("clear_keeps_cnt", 32'(lock_loss_cnt_o), CNT_EN ? 32'd1 : 32'd0);

    $display("[TB] software reset in RELEASE");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    tick(25);
    checkOutput("sw_pre_rst_n", 32'(rst_n_o), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sw_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("sw_done", 32'(rst_done_o), 32'h0);
    checkOutput("sw_no_flag", 32'(lock_lost_o), 32'h0);
    tick(15);
    checkOutput("sw_S15_rst_n", 32'(rst_n_o), 32'h0);
    tick(1);
    checkOutput("sw_S16_rst_n", 32'(rst_n_o), 32'h1);
    tick(25);
    checkOutput("sw_S41_done", 32'(rst_done_o), 32'h1);
    checkOutput("sw_S41_rst_n", 32'(rst_n_o), 32'hF);

    $display("[TB] clear racing a new lock loss");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("race_flag_set_wins", 32'(lock_lost_o), 32'h1);
    checkOutput("race_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("race_cnt2", 32'(lock_loss_cnt_o), CNT_EN ? 32'd2 : 32'd0);

    $display("[TB] lock loss with simultaneous software request");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    tick(5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold_clear", 32'(lock_lost_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("both_flag", 32'(lock_lost_o), 32'h1);
    checkOutput("both_cnt3", 32'(lock_loss_cnt_o), CNT_EN ? 32'd3 : 32'd0);
    tick(20);
    checkOutput("both_stays_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("both_stays_done", 32'(rst_done_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    tick(16);
    checkOutput("relock_E16", 32'(rst_n_o), 32'h0);
    tick(1);
    checkOutput("relock_E17", 32'(rst_n_o), 32'h1);

    $display("[TB] lock-loss counter saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(3);
    end
    checkOutput("sat_cnt", 32'(lock_loss_cnt_o), CNT_EN ? 32'hFF : 32'h0);
    checkOutput("sat_flag", 32'(lock_lost_o), 32'h1);

    $display("[TB] asynchronous reset mid-RUN");
    tick(50);
    checkOutput("run_done", 32'(rst_done_o), 32'h1);
    checkOutput("run_rst_n", 32'(rst_n_o), 32'hF);
    #2;
    rst_sys_n = 1'b0;
    #1;
    checkOutput("async_rst_n", 32'(rst_n_o), 32'h0);
    checkOutput("async_done", 32'(rst_done_o), 32'h0);
    checkOutput("async_flag", 32'(lock_lost_o), 32'h0);
    checkOutput("async_cnt", 32'(lock_loss_cnt_o), 32'h0);
    tick(2);
    rst_sys_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
